// File: rtl/npu_pool_pkg.sv
// Shared definitions for the pooling input/output address generators:
// FSM state encoding, default widths and the result word type.
package npu_pool_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_LEN_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pool_state_e;

  typedef logic [DEF_DATA_W-1:0] pool_word_t;

endpackage

// File: rtl/oagu_pooling_if.sv
// Result-in / buffer-write-out bus of the pooling output AGU.
// The slave side is the AGU; the master side feeds results and observes writes.
interface oagu_pooling_if
  import npu_pool_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              i_result_valid;
  logic [DATA_W-1:0] i_result_data;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [DATA_W-1:0] o_wr_data;
  logic              o_wr_en;

  modport slave (
    input  i_result_valid, i_result_data,
    output o_wr_addr, o_wr_data, o_wr_en
  );

  modport master (
    output i_result_valid, i_result_data,
    input  o_wr_addr, o_wr_data, o_wr_en
  );
endinterface

// File: rtl/oagu_pool_walker.sv
// Column/row/piece walker over the output feature map: holds the frame
// configuration, the position counters and the row/piece begin addresses.
module oagu_pool_walker
  import npu_pool_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [LEN_W-1:0]  i_x,
  input  logic [LEN_W-1:0]  i_y,
  input  logic [LEN_W-1:0]  i_pitch,
  input  logic [LEN_W-1:0]  i_piece,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_cur,
  output logic              o_last
);
  logic [LEN_W-1:0]  r_x, r_y, r_pitch, r_npiece;
  logic [LEN_W-1:0]  r_col, r_row, r_piece;
  logic [ADDR_W-1:0] r_cur, r_row_begin, r_piece_begin, r_step;
  logic [ADDR_W-1:0] w_pitch;
  logic              w_col_end, w_row_end, w_piece_end;

  assign w_pitch     = ADDR_W'(r_pitch);
  assign w_col_end   = (r_col   == r_x      - LEN_W'(1));
  assign w_row_end   = (r_row   == r_y      - LEN_W'(1));
  assign w_piece_end = (r_piece == r_npiece - LEN_W'(1));
  assign o_cur       = r_cur;
  assign o_last      = w_col_end && w_row_end && w_piece_end;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_x           <= '0;
      r_y           <= '0;
      r_pitch       <= '0;
      r_npiece      <= '0;
      r_col         <= '0;
      r_row         <= '0;
      r_piece       <= '0;
      r_cur         <= '0;
      r_row_begin   <= '0;
      r_piece_begin <= '0;
      r_step        <= '0;
    end else if (i_load) begin
      r_x           <= i_x;
      r_y           <= i_y;
      r_pitch       <= i_pitch;
      r_npiece      <= i_piece;
      r_col         <= '0;
      r_row         <= '0;
      r_piece       <= '0;
      r_cur         <= i_base;
      r_row_begin   <= i_base;
      r_piece_begin <= i_base;
      // piece stride, reduced modulo the address space like all other pointer math
      r_step        <= ADDR_W'(i_pitch) * ADDR_W'(i_y);
    end else if (i_advance) begin
      if (!w_col_end) begin
        r_col <= r_col + LEN_W'(1);
        r_cur <= r_cur + ADDR_W'(1);
      end else if (!w_row_end) begin
        r_col       <= '0;
        r_row       <= r_row + LEN_W'(1);
        r_row_begin <= r_row_begin + w_pitch;
        r_cur       <= r_row_begin + w_pitch;
      end else if (!w_piece_end) begin
        r_col         <= '0;
        r_row         <= '0;
        r_piece       <= r_piece + LEN_W'(1);
        r_piece_begin <= r_piece_begin + r_step;
        r_row_begin   <= r_piece_begin + r_step;
        r_cur         <= r_piece_begin + r_step;
      end
    end
  end
endmodule

// File: rtl/oagu_pooling.sv
// Pooling output AGU: writes each pooled result to the IO buffer one cycle
// after it arrives. Define OAGU_RELU_EN to clamp negative results to zero.
module oagu_pooling
  import npu_pool_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_calculate,
  input  logic [ADDR_W-1:0] addr_start_o,
  input  logic [LEN_W-1:0]  out_x_length,
  input  logic [LEN_W-1:0]  out_y_length,
  input  logic [LEN_W-1:0]  out_row_pitch,
  input  logic [LEN_W-1:0]  in_piece,
  oagu_pooling_if.slave     bus,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);
  pool_state_e       r_state;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_wr_en, r_busy, r_done, r_err;
  logic [ADDR_W-1:0] w_cur;
  logic              w_last, w_load, w_advance, w_empty;
  logic [DATA_W-1:0] w_data;

  assign w_empty   = (out_x_length == '0) || (out_y_length == '0) || (in_piece == '0);
  assign w_load    = (r_state == ST_IDLE) && start_calculate;
  assign w_advance = (r_state == ST_RUN) && bus.i_result_valid;

`ifdef OAGU_RELU_EN
  assign w_data = bus.i_result_data[DATA_W-1] ? '0 : bus.i_result_data;
`else
  assign w_data = bus.i_result_data;
`endif

  oagu_pool_walker #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_walker (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_base    (addr_start_o),
    .i_x       (out_x_length),
    .i_y       (out_y_length),
    .i_pitch   (out_row_pitch),
    .i_piece   (in_piece),
    .i_advance (w_advance),
    .o_cur     (w_cur),
    .o_last    (w_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.i_result_valid) r_err <= 1'b1;
          if (start_calculate) begin
            r_busy  <= 1'b1;
            r_state <= w_empty ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.i_result_valid) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= w_cur;
            r_wr_data <= w_data;
            if (w_last) r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // lands one cycle after the final write, or two after an empty start
          if (bus.i_result_valid) r_err <= 1'b1;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_wr_addr = r_wr_addr;
  assign bus.o_wr_data = r_wr_data;
  assign bus.o_wr_en   = r_wr_en;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err         = r_err;
endmodule

// File: tb/tb_oagu_pooling.sv
// Directed self-checking bench for oagu_pooling.
module tb_oagu_pooling;
  import npu_pool_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_calculate = 1'b0;
  logic [11:0] addr_start_o = '0;
  logic [7:0]  out_x_length = '0;
  logic [7:0]  out_y_length = '0;
  logic [7:0]  out_row_pitch = '0;
  logic [7:0]  in_piece = '0;
  logic        o_busy, o_done, o_err;
  int          n_checks = 0;
  int          n_pass = 0;

  oagu_pooling_if #(.DATA_W(16), .ADDR_W(12)) bus ();

  oagu_pooling dut (
    .clk             (clk),
    .rst             (rst),
    .start_calculate (start_calculate),
    .addr_start_o    (addr_start_o),
    .out_x_length    (out_x_length),
    .out_y_length    (out_y_length),
    .out_row_pitch   (out_row_pitch),
    .in_piece        (in_piece),
    .bus             (bus),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_err           (o_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives config and a one-cycle start; returns 1 time unit after the start edge.
  task automatic start_frame(input logic [11:0] base, input logic [7:0] x, input logic [7:0] y,
                             input logic [7:0] pitch, input logic [7:0] np);
    addr_start_o = base; out_x_length = x; out_y_length = y; out_row_pitch = pitch; in_piece = np;
    start_calculate = 1'b1;
    step();
    start_calculate = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.i_result_valid = 1'b0; bus.i_result_data = '0;
    step(); step();
    n_checks++; if ({bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, o_busy, o_done, o_err} !== '0)
      $display("FAIL reset_outputs: got en=%b addr=%h data=%h busy=%b done=%b err=%b want all 0",
               bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, o_busy, o_done, o_err); else n_pass++;
    rst = 1'b1;
    step();
  endtask

  task automatic test_contiguous();
    start_frame(12'h100, 8'd4, 8'd2, 8'd4, 8'd2);
    n_checks++; if (o_busy !== 1'b1) $display("FAIL contig_busy_rise: got %b want 1", o_busy); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      bus.i_result_valid = 1'b1; bus.i_result_data = 16'(i + 1);
      step();
      n_checks++; if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 12'(12'h100 + i) || bus.o_wr_data !== 16'(i + 1))
        $display("FAIL contig_write[%0d]: got en=%b addr=%h data=%h want en=1 addr=%h data=%h",
                 i, bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, 12'(12'h100 + i), 16'(i + 1)); else n_pass++;
      n_checks++; if (o_busy !== 1'b1 || o_done !== 1'b0)
        $display("FAIL contig_status[%0d]: got busy=%b done=%b want busy=1 done=0", i, o_busy, o_done); else n_pass++;
    end
    bus.i_result_valid = 1'b0;
    step();
    n_checks++; if (o_done !== 1'b1 || o_busy !== 1'b0 || bus.o_wr_en !== 1'b0)
      $display("FAIL contig_done: got done=%b busy=%b en=%b want done=1 busy=0 en=0", o_done, o_busy, bus.o_wr_en); else n_pass++;
    step();
    n_checks++; if (o_done !== 1'b0) $display("FAIL contig_done_single: got %b want 0", o_done); else n_pass++;
  endtask

  task automatic test_pitch();
    logic [11:0] exp_addr [16] = '{12'h100, 12'h101, 12'h102, 12'h103, 12'h106, 12'h107, 12'h108, 12'h109,
                                   12'h10C, 12'h10D, 12'h10E, 12'h10F, 12'h112, 12'h113, 12'h114, 12'h115};
    start_frame(12'h100, 8'd4, 8'd2, 8'd6, 8'd2);
    for (int i = 0; i < 16; i++) begin
      bus.i_result_valid = 1'b1; bus.i_result_data = 16'(16'h0200 + i);
      step();
      n_checks++; if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== exp_addr[i])
        $display("FAIL pitch_addr[%0d]: got en=%b addr=%h want en=1 addr=%h", i, bus.o_wr_en, bus.o_wr_addr, exp_addr[i]); else n_pass++;
    end
    bus.i_result_valid = 1'b0;
    step();
    n_checks++; if (o_done !== 1'b1) $display("FAIL pitch_done: got %b want 1", o_done); else n_pass++;
    step();
  endtask

  task automatic test_gapped();
    start_frame(12'h200, 8'd2, 8'd1, 8'd2, 8'd2);
    for (int i = 0; i < 4; i++) begin
      bus.i_result_valid = 1'b1; bus.i_result_data = 16'(16'h00A0 + i);
      step();
      n_checks++; if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 12'(12'h200 + i) || bus.o_wr_data !== 16'(16'h00A0 + i))
        $display("FAIL gap_write[%0d]: got en=%b addr=%h data=%h want en=1 addr=%h data=%h",
                 i, bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, 12'(12'h200 + i), 16'(16'h00A0 + i)); else n_pass++;
      bus.i_result_valid = 1'b0;
      step();
      n_checks++; if (bus.o_wr_en !== 1'b0 || o_done !== (i == 3))
        $display("FAIL gap_idle1[%0d]: got en=%b done=%b want en=0 done=%b", i, bus.o_wr_en, o_done, (i == 3)); else n_pass++;
      step();
      n_checks++; if (bus.o_wr_en !== 1'b0 || o_done !== 1'b0)
        $display("FAIL gap_idle2[%0d]: got en=%b done=%b want en=0 done=0", i, bus.o_wr_en, o_done); else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [11:0] exp_addr [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    start_frame(12'hFFE, 8'd4, 8'd1, 8'd4, 8'd1);
    for (int i = 0; i < 4; i++) begin
      bus.i_result_valid = 1'b1; bus.i_result_data = 16'(16'h0300 + i);
      step();
      n_checks++; if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== exp_addr[i])
        $display("FAIL wrap_addr[%0d]: got en=%b addr=%h want en=1 addr=%h", i, bus.o_wr_en, bus.o_wr_addr, exp_addr[i]); else n_pass++;
    end
    bus.i_result_valid = 1'b0;
    step();
    n_checks++; if (o_done !== 1'b1) $display("FAIL wrap_done: got %b want 1", o_done); else n_pass++;
    step();
  endtask

  task automatic test_relu();
    logic [15:0] exp_neg;
`ifdef OAGU_RELU_EN
    exp_neg = 16'h0000;
`else
    exp_neg = 16'h8001;
`endif
    start_frame(12'h040, 8'd2, 8'd1, 8'd2, 8'd1);
    bus.i_result_valid = 1'b1; bus.i_result_data = 16'h8001;
    step();
    n_checks++; if (bus.o_wr_en !== 1'b1 || bus.o_wr_data !== exp_neg)
      $display("FAIL relu_neg: got en=%b data=%h want en=1 data=%h", bus.o_wr_en, bus.o_wr_data, exp_neg); else n_pass++;
    bus.i_result_data = 16'h7FFF;
    step();
    n_checks++; if (bus.o_wr_en !== 1'b1 || bus.o_wr_data !== 16'h7FFF || bus.o_wr_addr !== 12'h041)
      $display("FAIL relu_pos: got en=%b addr=%h data=%h want en=1 addr=041 data=7fff",
               bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data); else n_pass++;
    bus.i_result_valid = 1'b0;
    step(); step();
  endtask

  task automatic test_empty_and_err();
    start_frame(12'h100, 8'd4, 8'd0, 8'd4, 8'd2);
    n_checks++; if (bus.o_wr_en !== 1'b0 || o_done !== 1'b0)
      $display("FAIL empty_cycle1: got en=%b done=%b want en=0 done=0", bus.o_wr_en, o_done); else n_pass++;
    step();
    n_checks++; if (o_done !== 1'b1 || bus.o_wr_en !== 1'b0)
      $display("FAIL empty_done: got done=%b en=%b want done=1 en=0", o_done, bus.o_wr_en); else n_pass++;
    step();
    n_checks++; if (o_done !== 1'b0 || o_err !== 1'b0)
      $display("FAIL empty_after: got done=%b err=%b want done=0 err=0", o_done, o_err); else n_pass++;
    bus.i_result_valid = 1'b1; bus.i_result_data = 16'h1234;
    step();
    bus.i_result_valid = 1'b0;
    n_checks++; if (o_err !== 1'b1 || bus.o_wr_en !== 1'b0)
      $display("FAIL idle_valid_err: got err=%b en=%b want err=1 en=0", o_err, bus.o_wr_en); else n_pass++;
    step(); step(); step();
    n_checks++; if (o_err !== 1'b1) $display("FAIL err_sticky: got %b want 1", o_err); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    start_frame(12'h100, 8'd4, 8'd2, 8'd4, 8'd2);
    for (int i = 0; i < 5; i++) begin
      bus.i_result_valid = 1'b1; bus.i_result_data = 16'(i + 1);
      step();
      n_checks++; if (bus.o_wr_addr !== 12'(12'h100 + i))
        $display("FAIL mid_addr[%0d]: got %h want %h", i, bus.o_wr_addr, 12'(12'h100 + i)); else n_pass++;
    end
    bus.i_result_valid = 1'b0;
    rst = 1'b0;
    step();
    n_checks++; if ({bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, o_busy, o_done, o_err} !== '0)
      $display("FAIL mid_reset: got en=%b addr=%h data=%h busy=%b done=%b err=%b want all 0",
               bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, o_busy, o_done, o_err); else n_pass++;
    rst = 1'b1;
    step();
    n_checks++; if (o_done !== 1'b0) $display("FAIL mid_no_done: got %b want 0", o_done); else n_pass++;
    start_frame(12'h100, 8'd4, 8'd2, 8'd4, 8'd2);
    for (int i = 0; i < 2; i++) begin
      bus.i_result_valid = 1'b1; bus.i_result_data = 16'(16'h0050 + i);
      step();
      n_checks++; if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 12'(12'h100 + i))
        $display("FAIL restart_addr[%0d]: got en=%b addr=%h want en=1 addr=%h",
                 i, bus.o_wr_en, bus.o_wr_addr, 12'(12'h100 + i)); else n_pass++;
    end
    bus.i_result_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_contiguous();
    test_pitch();
    test_gapped();
    test_wrap();
    test_relu();
    test_empty_and_err();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/oagu_pooling.md
Name: oagu_pooling

Overview:
Output address generation unit for the pooling datapath. It is the write-side partner of the pooling input AGU. It accepts pooled results from the pooling unit, one per valid pulse, and writes each to the IO buffer. Write addresses walk column, then row, then piece over the output feature map described by the decoder. Started by the scheduler's start_calculate pulse; reports completion back to the scheduler.

Parameters:
DATA_W, 16, width of one pooled result word
ADDR_W, 12, IO buffer address width (matches decoder addr fields)
LEN_W, 8, width of x/y/piece length fields

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (rst==0 resets on rising clk)
start_calculate  in  1  one-cycle start pulse from schedule
addr_start_o  in  ADDR_W  output region base address from decoder
out_x_length  in  LEN_W  output columns per row
out_y_length  in  LEN_W  output rows per piece
out_row_pitch  in  LEN_W  buffer words between row starts (>= out_x_length)
in_piece  in  LEN_W  piece count (pooling: out_piece == in_piece)
i_result_valid  in  1  pooled result valid, one word per pulse
i_result_data  in  DATA_W  pooled result
o_wr_addr  out  ADDR_W  IO buffer write address
o_wr_data  out  DATA_W  IO buffer write data
o_wr_en  out  1  IO buffer write strobe
o_busy  out  1  high from accepted start until done
o_done  out  1  one-cycle pulse after the last write
o_err  out  1  sticky: result arrived while IDLE/DONE

Behaviour:
- Reset (rst==0 at clk edge): state IDLE. All counters, begin-address registers, o_wr_addr, o_wr_data, o_wr_en, o_busy, o_done and o_err are cleared to 0. Reset mid-frame aborts the frame immediately; no o_done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE: on start_calculate the unit latches addr_start_o, out_x_length, out_y_length, out_row_pitch and in_piece.
  - If any of out_x_length, out_y_length or in_piece is 0, go to DONE (no writes).
  - Otherwise go to RUN. Set row_begin = piece_begin = cur = addr_start_o and clear col/row/piece counters.
  - o_busy rises the cycle after start.
- RUN: for each cycle with i_result_valid=1, the next cycle drives o_wr_en=1, o_wr_addr=cur, o_wr_data=i_result_data (latency 1, one write per result, back-to-back supported). Pointers then update:
  - col < out_x-1: col++, cur++.
  - Else, row < out_y-1: col=0, row++, row_begin += pitch, cur = row_begin + pitch.
  - Else, piece < in_piece-1: col=row=0, piece++, piece_begin += pitch*out_y (precomputed at start, ADDR_W-wide), row_begin = cur = new piece_begin.
  - Else (last word): go to DONE.
- DONE: o_done=1 for exactly one cycle, coinciding with the cycle after the last o_wr_en. o_busy drops in that same cycle. Then return to IDLE.
- start_calculate while RUN/DONE is ignored. The latched config stays stable all frame; decoder changes mid-frame have no effect.
- i_result_valid in IDLE/DONE: no write; o_err set to 1 and held until reset.
- Address arithmetic is modulo 2^ADDR_W (wraps, no error).
- pitch < out_x_length is a configuration error: behaviour is defined by the formulas above, not flagged.
- o_wr_en is 0 in every cycle that has no write.

Optional Feature:
Macro OAGU_RELU_EN.
- Defined: o_wr_data = 0 when i_result_data is negative (two's-complement MSB=1), else i_result_data. Latency is unchanged.
- Undefined: data passes through unchanged.

Decomposition:
- Shared package npu_pool_pkg holds the FSM state encoding (IDLE/RUN/DONE), ADDR_W/LEN_W/DATA_W defaults and the DATA_W word typedef. The same package is used by the input AGU.
- One natural sub-module, oagu_pool_walker: col/row/piece counters plus begin-address registers. It provides next-address and last-word outputs. The top holds the FSM, the write register stage and the error flag.

Test Plan:
- Base 0x100, out_x=4, out_y=2, pitch=4, piece=2, 16 back-to-back valids with data 1..16 -> writes to 0x100..0x10F in order with matching data; o_done in the cycle after the 16th write; o_busy high 17 cycles.
- Same config with pitch=6 -> addresses 0x100-0x103, 0x106-0x109 (piece 0), 0x10C-0x10F, 0x112-0x115 (piece 1).
- Valids gapped 1-on/2-off -> each write lands exactly 1 cycle after its valid; o_done 1 cycle after the last write.
- out_y=0 with start pulse -> no o_wr_en; o_done pulses 2 cycles after start. A valid while idle -> o_err=1, stays 1.
- Base 0xFFE, out_x=4, out_y=1, piece=1 -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
- rst=0 after 5 of 16 writes -> all outputs 0 next cycle, no o_done; a new start then restarts from the base address. With OAGU_RELU_EN, data 0x8001 -> written as 0x0000.
